// File: rtl/data_mem_responder.sv
// Load/store data memory with byte/half/word access, sign/zero extension and a
// fixed number of wait states between accept and the one-cycle response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_mode_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  mode_q, mode_d;
  logic        uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        go_resp;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the access completes on the accepting edge, so the
  // operands come straight from the inputs while still in IDLE.
  logic          acc_write;
  logic [1:0]    acc_mode;
  logic          acc_uns;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [IDX_W-1:0] acc_idx;

  assign acc_write = (state_q == S_IDLE) ? mem_write_i      : write_q;
  assign acc_mode  = (state_q == S_IDLE) ? mem_mode_i       : mode_q;
  assign acc_uns   = (state_q == S_IDLE) ? unsigned_i       : uns_q;
  assign acc_addr  = (state_q == S_IDLE) ? addr_i[AW-1:0]   : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? wdata_i          : wdata_q;
  assign acc_idx   = acc_addr[AW-1:2];

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW];

  logic        acc_err;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic        mem_we;

  always_comb begin
    acc_err = 1'b0;
    wr_be   = 4'b0000;
    wr_data = acc_wdata;
    case (acc_mode)
      2'b00: begin
        wr_be   = 4'b0001 << acc_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        acc_err = acc_addr[0];
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        acc_err = |acc_addr[1:0];
        wr_be   = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_word = mem_q[acc_idx];
    case (acc_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_mode)
      2'b00:   load_val = acc_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = acc_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    mode_d  = mode_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          write_d = mem_write_i;
          mode_d  = mem_mode_i;
          uns_d   = unsigned_i;
          addr_d  = addr_i[AW-1:0];
          wdata_d = wdata_i;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Load data, store zero and error flag all land on the edge entering RESP.
    if (go_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'd0 : load_val;
    end
  end

  assign mem_we = go_resp && acc_write && !acc_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      mode_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      mode_q  <= mode_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[acc_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign ready_o = (state_q == S_RESP);
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 1, 3 and 0
// wait states sharing the operand inputs but with separate request strobes.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req1, req3, req0;
  logic        mem_write;
  logic [1:0]  mem_mode;
  logic        uns;
  logic [31:0] addr, wdata;
  logic [31:0] rd1, rd3, rd0;
  logic        rdy1, rdy3, rdy0, er1, er3, er0, bz1, bz3, bz0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req1), .mem_write_i(mem_write),
    .mem_mode_i(mem_mode), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd1), .ready_o(rdy1), .err_o(er1), .busy_o(bz1));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .mem_write_i(mem_write),
    .mem_mode_i(mem_mode), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd3), .ready_o(rdy3), .err_o(er3), .busy_o(bz3));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req0), .mem_write_i(mem_write),
    .mem_mode_i(mem_mode), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd0), .ready_o(rdy0), .err_o(er0), .busy_o(bz0));

  typedef struct packed {
    logic        wr;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [1:0] mode, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.wr = wr; v.mode = mode; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rd = erd; v.exp_err = eerr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int inst, input logic v);
    case (inst)
      0: req0 = v;
      3: req3 = v;
      default: req1 = v;
    endcase
  endtask

  task automatic get_out(input int inst, output logic r, output logic e,
                         output logic b, output logic [31:0] d);
    case (inst)
      0: begin r = rdy0; e = er0; b = bz0; d = rd0; end
      3: begin r = rdy3; e = er3; b = bz3; d = rd3; end
      default: begin r = rdy1; e = er1; b = bz1; d = rd1; end
    endcase
  endtask

  task automatic drive(input logic wr, input logic [1:0] mode, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_write = wr; mem_mode = mode; uns = u; addr = a; wdata = wd;
  endtask

  // One accepted access; lat is the number of falling edges until ready (0 = timeout).
  task automatic access(input int inst, input logic wr, input logic [1:0] mode,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic r, e, b;
    logic [31:0] d;
    @(negedge clk);
    drive(wr, mode, u, a, wd);
    set_req(inst, 1'b1);
    @(posedge clk);
    #1 set_req(inst, 1'b0);
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      get_out(inst, r, e, b, d);
      if (r) begin
        lat = i; rd = d; er = e;
        break;
      end
    end
    $display("access inst=%0d wr=%0b mode=%0d uns=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d",
             inst, wr, mode, u, a, wd, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er, r, e, b;
  logic [31:0] d;
  int          lat, cnt;

  initial begin
    rst_ni = 1'b0; req1 = 1'b0; req3 = 1'b0; req0 = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Directed vectors on the 1-wait-state instance
    add(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(1, 2'b00, 0, 32'h20,  32'h11,       32'h0,        0);
    add(1, 2'b00, 0, 32'h21,  32'h22,       32'h0,        0);
    add(1, 2'b00, 0, 32'h22,  32'h33,       32'h0,        0);
    add(1, 2'b00, 0, 32'h23,  32'h44,       32'h0,        0);
    add(0, 2'b10, 0, 32'h20,  32'h0,        32'h44332211, 0);
    add(1, 2'b01, 0, 32'h22,  32'hAAAA,     32'h0,        0);
    add(0, 2'b10, 0, 32'h20,  32'h0,        32'hAAAA2211, 0);
    add(1, 2'b10, 0, 32'h20,  32'h0000F080, 32'h0,        0);
    add(0, 2'b00, 0, 32'h20,  32'h0,        32'hFFFFFF80, 0);
    add(0, 2'b00, 1, 32'h20,  32'h0,        32'h00000080, 0);
    add(0, 2'b01, 0, 32'h20,  32'h0,        32'hFFFFF080, 0);
    add(0, 2'b01, 1, 32'h20,  32'h0,        32'h0000F080, 0);
    add(0, 2'b00, 0, 32'h21,  32'h0,        32'hFFFFFFF0, 0);
    add(0, 2'b00, 1, 32'h21,  32'h0,        32'h000000F0, 0);
    add(0, 2'b01, 0, 32'h22,  32'h0,        32'h00000000, 0);
    add(0, 2'b10, 0, 32'h21,  32'h0,        32'h0,        1);
    add(1, 2'b01, 0, 32'h23,  32'h5555,     32'h0,        1);
    add(0, 2'b10, 0, 32'h20,  32'h0,        32'h0000F080, 0);
    add(0, 2'b11, 0, 32'h20,  32'h0,        32'h0,        1);
    add(1, 2'b10, 0, 32'h40,  32'h11112222, 32'h0,        0);
    add(1, 2'b10, 0, 32'h400, 32'h12345678, 32'h0,        0);
    add(0, 2'b10, 0, 32'h0,   32'h0,        32'h12345678, 0);
    add(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);

    repeat (3) @(negedge clk);
    check("reset_rdata", rd1, 32'd0);
    check("reset_ready", {31'd0, rdy1}, 32'd0);
    check("reset_err",   {31'd0, er1},  32'd0);
    check("reset_busy",  {31'd0, bz1},  32'd0);
    rst_ni = 1'b1;

    foreach (vecs[k]) begin
      access(1, vecs[k].wr, vecs[k].mode, vecs[k].uns, vecs[k].addr, vecs[k].wdata, rd, er, lat);
      check($sformatf("v%0d_latency", k), lat, 32'd2);
      check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
      check($sformatf("v%0d_err", k), {31'd0, er}, {31'd0, vecs[k].exp_err});
      @(negedge clk);
      check($sformatf("v%0d_ready_width", k), {31'd0, rdy1}, 32'd0);
      check($sformatf("v%0d_err_clear", k), {31'd0, er1}, 32'd0);
      check($sformatf("v%0d_rdata_hold", k), rd1, vecs[k].exp_rd);
    end

    // Reset during WAIT aborts the store
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'h99999999);
    req1 = 1'b1;
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'd0, bz1}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_rdata", rd1, 32'd0);
    check("abort_ready", {31'd0, rdy1}, 32'd0);
    check("abort_err",   {31'd0, er1},  32'd0);
    check("abort_busy",  {31'd0, bz1},  32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy1) cnt++;
    end
    check("abort_no_ready", cnt, 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("abort_old_value", rd, 32'h11112222);

    // Zero wait states: ready the cycle after accept
    access(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0BADCAFE, rd, er, lat);
    check("ws0_store_latency", lat, 32'd1);
    access(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat);
    check("ws0_load_latency", lat, 32'd1);
    check("ws0_load_rdata", rd, 32'h0BADCAFE);
    access(0, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, rd, er, lat);
    check("ws0_lb_hi", rd, 32'h0000000B);
    access(0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, rd, er, lat);
    check("ws0_lb_lo", rd, 32'hFFFFFFFE);
    access(0, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, rd, er, lat);
    check("ws0_lh_hi", rd, 32'h00000BAD);

    // Three wait states: dropped request while busy
    access(3, 1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, rd, er, lat);
    check("ws3_store_latency", lat, 32'd4);
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    req3 = 1'b1;
    @(posedge clk);
    #1 req3 = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h8, 32'hBAD0BAD0);
    req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    cnt = 0;
    d = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdy3) begin
        cnt++;
        d = rd3;
      end
    end
    $display("drop test: ready pulses=%0d rdata=0x%08h", cnt, d);
    check("ws3_drop_pulses", cnt, 32'd1);
    check("ws3_drop_rdata", d, 32'hCAFEF00D);
    access(3, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat);
    check("ws3_drop_mem", rd, 32'hCAFEF00D);

    // Three wait states: request held high accepts every 5 cycles
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    req3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", i), {31'd0, rdy3}, {31'd0, (i % 5) == 4});
      check($sformatf("hold_busy_%0d", i),  {31'd0, bz3},  {31'd0, (i % 5) != 0});
    end
    req3 = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the load/store path of the RISC-V core. Services byte, half-word and word requests using the same `mem_mode` encoding the controller drives: 00 byte, 01 half-word, 10 word. Stores use per-byte lanes. Loads are sign- or zero-extended. Each access passes through a request/ready handshake with a programmable number of wait states, so the block can stand in for a slower memory.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two.
- `WAIT_STATES`, default 1: extra cycles between accept and response, legal range 0..7.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: request strobe.
- `mem_write_i` in 1: 1 = store, 0 = load.
- `mem_mode_i` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_i` in 1: 1 = zero-extend load (lbu/lhu); ignored for word loads and for stores.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-aligned.
- `rdata_o` out 32: load result.
- `ready_o` out 1: one-cycle response pulse.
- `err_o` out 1: misaligned or illegal-mode flag, valid while `ready_o` is 1.
- `busy_o` out 1: a request is in flight; new requests are ignored.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **Accept.** In IDLE, `req_i`=1 at a rising edge captures `mem_write_i`, `mem_mode_i`, `unsigned_i`, `addr_i` and `wdata_i`.
  - With `WAIT_STATES`=0 the FSM goes to RESP.
  - Otherwise it goes to WAIT with the counter loaded to `WAIT_STATES`-1.
- **WAIT.** The counter decrements each cycle. The FSM goes to RESP on the edge where the counter is 0.
- **RESP.** The FSM stays one cycle with `ready_o`=1, then returns to IDLE. `req_i` is not sampled in RESP.
- `req_i` is ignored whenever `busy_o`=1; ignored requests have no effect and are not queued.
- **Word index.** `addr_i[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS`\*4.
- **Error.** The access is an error for:
  - a half-word with `addr[0]`=1;
  - a word with `addr[1:0]`≠0;
  - mode 11.
  
  On error there is no array write, `rdata_o`=0 and `err_o`=1 in RESP.
- **Store lanes:**
  - byte writes lane `addr[1:0]` with `wdata[7:0]`;
  - half writes lanes {`addr[1]`,0} and {`addr[1]`,1} with `wdata[15:0]`;
  - word writes all lanes.
  
  Other lanes are unchanged.
- **Load result:**
  - byte selects lane `addr[1:0]`;
  - half selects the upper or lower 16 bits by `addr[1]`;
  - bit 7 or 15 is replicated upward unless `unsigned_i`=1, in which case the upper bits are 0.
- **Store response data.** `rdata_o`=0 in RESP for stores.
- **Reset.** Reset clears the FSM to IDLE, the counter to 0 and all outputs to 0. The memory array is not reset; its contents are undefined until written.

## Timing
- Reset values: `rdata_o`=0, `ready_o`=0, `err_o`=0, `busy_o`=0.
- A request accepted at edge k gives `ready_o`=1 during cycle k+1+`WAIT_STATES` only.
- `busy_o`=1 from cycle k+1 through the RESP cycle, inclusive.
- The earliest next accept is at the edge ending RESP+1, i.e. the first IDLE cycle. Throughput is one access per 2+`WAIT_STATES` cycles.
- **Load data.** The array read and extension are registered on the edge entering RESP. `rdata_o` is valid and stable in the RESP cycle and holds its value until the next RESP.
- **Store commit.** The store commits on the edge entering RESP. A load accepted afterwards to the same word returns the new data (read-after-write coherent).
- `err_o` is cleared on the edge leaving RESP.
- **Reset mid-operation.** Asserting `rst_ni`=0 in WAIT aborts the access: no write, no `ready_o`. Asserting it in RESP does not undo an already-committed store.

## Test plan
- **Word round-trip** (`WAIT_STATES`=1): store 0xDEADBEEF at 0x10, then load word 0x10 → `ready_o` 2 cycles after each accept, `rdata_o`=0xDEADBEEF, `err_o`=0.
- **Byte lanes:**
  - store bytes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then load word 0x20 → 0x44332211;
  - store half 0xAAAA at 0x22 → word reads 0xAAAA2211.
- **Extension:** word 0x20 = 0x0000F080:
  - lb 0x20 → 0xFFFFFF80;
  - lbu 0x20 → 0x00000080;
  - lh 0x20 → 0xFFFFF080;
  - lhu → 0x0000F080.
- **Errors:**
  - lw 0x21 → `err_o`=1, `rdata_o`=0;
  - sh 0x23 → `err_o`=1 and memory unchanged;
  - mode 11 → `err_o`=1.
- **Handshake** (`WAIT_STATES`=3):
  - `req_i` held high continuously → accepts every 5 cycles;
  - `ready_o` is exactly 1 cycle wide;
  - requests during `busy_o` are dropped.
  
  With `WAIT_STATES`=0 → `ready_o` the cycle after accept.
- **Reset and wrap:**
  - store to 0x40, assert `rst_ni` low in WAIT → outputs 0, and a later load of 0x40 shows the old value;
  - with `DEPTH_WORDS`=256, a store to 0x400 aliases 0x000.
